// File: rtl/aidan_mcnay_deser_ctrl_if.sv
// Bus bundle for the deserialiser framing controller.
//
// Groups every non-clock/reset signal of aidan_mcnay_deser_ctrl:
//   ser_val, ser_data, frame_clr : serial bit stream in, plus frame abort
//   sipo_en, sipo_data_in        : shift control/data out to the SIPO
//   sipo_data_out                : SIPO parallel word back in (newest bit at LSB)
//   out_msg, out_val, out_rdy    : captured word offered downstream (val/rdy)
//   busy, overrun                : status (partial word in flight / word dropped)
//
// Modports:
//   master : the controller side (drives sipo_*, out_msg/out_val, status)
//   slave  : the environment side (serial source, SIPO, downstream sink)
interface aidan_mcnay_deser_ctrl_if #(
  parameter int nbits = 16
);
  logic             ser_val;
  logic             ser_data;
  logic             frame_clr;
  logic             sipo_en;
  logic             sipo_data_in;
  logic [nbits-1:0] sipo_data_out;
  logic [nbits-1:0] out_msg;
  logic             out_val;
  logic             out_rdy;
  logic             busy;
  logic             overrun;

  modport master (
    input  ser_val, ser_data, frame_clr, sipo_data_out, out_rdy,
    output sipo_en, sipo_data_in, out_msg, out_val, busy, overrun
  );

  modport slave (
    output ser_val, ser_data, frame_clr, sipo_data_out, out_rdy,
    input  sipo_en, sipo_data_in, out_msg, out_val, busy, overrun
  );
endinterface

// File: rtl/aidan_mcnay_deser_ctrl.sv
// Framing controller wrapped around the SIPO on the prime detector input path.
//
// Forwards each strobed serial bit straight to the SIPO, counts bits, and one
// cycle after the last bit of a word captures the SIPO's parallel output into
// out_msg. The captured word is offered downstream with a val/rdy handshake;
// a completed word that cannot be captured because the previous one is still
// unaccepted is dropped and flagged on the sticky overrun output.
//
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous, active-high reset
//   bus   : aidan_mcnay_deser_ctrl_if.master (serial in, SIPO control, output
//           handshake and status)
module aidan_mcnay_deser_ctrl #(
  parameter int nbits = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  aidan_mcnay_deser_ctrl_if.master  bus
);

  localparam int CW = (nbits > 1) ? $clog2(nbits) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(nbits - 1);

  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             pending_q, pending_d;
  logic [nbits-1:0] out_msg_q, out_msg_d;
  logic             out_val_q, out_val_d;
  logic             overrun_q, overrun_d;

  logic             accept;
  logic             capture;
  logic             drop;

  // Bits presented during reset or an abort must not reach the SIPO.
  assign accept           = bus.ser_val & ~bus.frame_clr & ~reset;
  assign bus.sipo_en      = accept;
  assign bus.sipo_data_in = bus.ser_data;

  // In the pending cycle the SIPO still holds the complete word even if a new
  // bit is being shifted this cycle: the capture edge sees pre-shift contents.
  assign capture = pending_q & ~bus.frame_clr & (~out_val_q | bus.out_rdy);
  assign drop    = pending_q & ~bus.frame_clr &  out_val_q & ~bus.out_rdy;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    pending_d = 1'b0;
    out_msg_d = out_msg_q;
    out_val_d = out_val_q;
    overrun_d = overrun_q | drop;

    // Output register: a capture wins over a plain handshake so that a word
    // accepted on the same edge is immediately replaced without a gap.
    if (capture) begin
      out_msg_d = bus.sipo_data_out;
      out_val_d = 1'b1;
    end else if (out_val_q && bus.out_rdy) begin
      out_val_d = 1'b0;
    end

    if (bus.frame_clr) begin
      bit_cnt_d = '0;
    end else if (accept) begin
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        pending_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= '0;
      pending_q <= 1'b0;
      out_msg_q <= '0;
      out_val_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      pending_q <= pending_d;
      out_msg_q <= out_msg_d;
      out_val_q <= out_val_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.out_msg = out_msg_q;
  assign bus.out_val = out_val_q;
  assign bus.overrun = overrun_q;
  assign bus.busy    = (bit_cnt_q != '0);

endmodule

// File: tb/tb_aidan_mcnay_deser_ctrl.sv
// Self-checking bench for aidan_mcnay_deser_ctrl (nbits = 16).
// Contains a behavioural SIPO so the controller sees a real parallel word, a
// word-level reference model, a short table of hand-derived vectors, directed
// multi-cycle scenarios and a randomized run.
module tb_aidan_mcnay_deser_ctrl;
  localparam int NB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aidan_mcnay_deser_ctrl_if #(.nbits(NB)) ifc ();

  aidan_mcnay_deser_ctrl #(.nbits(NB)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (ifc)
  );

  // Behavioural SIPO: newest bit enters at the LSB, never reset.
  logic [NB-1:0] sipo_q = '0;
  always_ff @(posedge clk) begin
    if (ifc.sipo_en) sipo_q <= {sipo_q[NB-2:0], ifc.sipo_data_in};
  end
  assign ifc.sipo_data_out = sipo_q;

  int checks = 0;
  int failures = 0;

  // Reference model state (word level).
  longint unsigned m_hist = 0;   // every accepted bit as a number mod 2^NB
  int              m_nbits = 0;  // bits collected toward the current word
  bit              m_pend = 0;
  longint unsigned m_pword = 0;
  bit              m_val = 0;
  longint unsigned m_msg = 0;
  bit              m_ovr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit d, input bit clr, input bit rdy, input bit r);
    ifc.ser_val   = v;
    ifc.ser_data  = d;
    ifc.frame_clr = clr;
    ifc.out_rdy   = rdy;
    rst           = r;
    #1;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit acc;
    if (rst) begin
      m_nbits = 0; m_pend = 0; m_val = 0; m_msg = 0; m_ovr = 0;
    end else begin
      acc = ifc.ser_val && !ifc.frame_clr;
      if (m_pend && !ifc.frame_clr) begin
        if (!m_val || ifc.out_rdy) begin
          m_msg = m_pword;
          m_val = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (m_val && ifc.out_rdy) begin
        m_val = 0;
      end
      m_pend = 0;
      if (ifc.frame_clr) m_nbits = 0;
      if (acc) begin
        m_hist = (m_hist * 2 + longint'(ifc.ser_data)) % (64'd1 << NB);
        m_nbits++;
        if (m_nbits == NB) begin
          m_nbits = 0;
          m_pend = 1;
          m_pword = m_hist;
        end
      end
    end
    // The SIPO keeps shifting history independently of reset only when
    // sipo_en is high, which is never the case during reset.
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".out_val"}, 32'(ifc.out_val), 32'(m_val));
    chk({tag, ".out_msg"}, 32'(ifc.out_msg), 32'(m_msg));
    chk({tag, ".overrun"}, 32'(ifc.overrun), 32'(m_ovr));
    chk({tag, ".busy"},    32'(ifc.busy),    32'(m_nbits != 0));
  endtask

  task automatic cycle(input string tag, input bit v, input bit d, input bit clr,
                       input bit rdy, input bit r);
    drive(v, d, clr, rdy, r);
    chk({tag, ".sipo_en"}, 32'(ifc.sipo_en), 32'(v && !clr && !r));
    chk({tag, ".sipo_data_in"}, 32'(ifc.sipo_data_in), 32'(d));
    tick();
    cmp_model(tag);
  endtask

  task automatic shift_word(input string tag, input logic [NB-1:0] w, input bit rdy);
    for (int i = NB - 1; i >= 0; i--) cycle(tag, 1'b1, w[i], 1'b0, rdy, 1'b0);
  endtask

  typedef struct {
    bit v, d, clr, rdy, r;
    bit e_en, e_val, e_busy, e_ovr;
    logic [NB-1:0] e_msg;
  } vec_t;

  vec_t tab [8];

  initial begin
    ifc.ser_val = 0; ifc.ser_data = 0; ifc.frame_clr = 0; ifc.out_rdy = 0;

    // Hand-derived vectors: reset state, bit counting, abort, reset.
    tab[0] = '{1,1,0,0,1, 0,0,0,0, 16'h0};
    tab[1] = '{1,1,0,0,0, 1,0,1,0, 16'h0};
    tab[2] = '{1,0,0,0,0, 1,0,1,0, 16'h0};
    tab[3] = '{1,1,1,0,0, 0,0,0,0, 16'h0};
    tab[4] = '{0,1,0,1,0, 0,0,0,0, 16'h0};
    tab[5] = '{1,1,0,0,0, 1,0,1,0, 16'h0};
    tab[6] = '{1,1,0,1,1, 0,0,0,0, 16'h0};
    tab[7] = '{0,0,0,1,0, 0,0,0,0, 16'h0};
    for (int i = 0; i < 8; i++) begin
      drive(tab[i].v, tab[i].d, tab[i].clr, tab[i].rdy, tab[i].r);
      chk($sformatf("tab%0d.sipo_en", i), 32'(ifc.sipo_en), 32'(tab[i].e_en));
      tick();
      chk($sformatf("tab%0d.out_val", i), 32'(ifc.out_val), 32'(tab[i].e_val));
      chk($sformatf("tab%0d.out_msg", i), 32'(ifc.out_msg), 32'(tab[i].e_msg));
      chk($sformatf("tab%0d.busy", i),    32'(ifc.busy),    32'(tab[i].e_busy));
      chk($sformatf("tab%0d.overrun", i), 32'(ifc.overrun), 32'(tab[i].e_ovr));
    end

    // Single word, 2-cycle latency, one-cycle valid with rdy held high.
    cycle("w1", 0, 0, 0, 1, 1);
    shift_word("w1", 16'hFFF1, 1'b1);
    chk("w1.busy_after_wrap", 32'(ifc.busy), 32'd0);
    chk("w1.val_n1", 32'(ifc.out_val), 32'd0);
    cycle("w1", 0, 0, 0, 1, 0);
    chk("w1.val_n2", 32'(ifc.out_val), 32'd1);
    chk("w1.msg", 32'(ifc.out_msg), 32'hFFF1);
    cycle("w1", 0, 0, 0, 1, 0);
    chk("w1.val_drop", 32'(ifc.out_val), 32'd0);

    // Backpressure hold.
    shift_word("bp", 16'h0007, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle("bp", 0, 0, 0, 0, 0);
      if (i > 0) begin
        chk("bp.hold_val", 32'(ifc.out_val), 32'd1);
        chk("bp.hold_msg", 32'(ifc.out_msg), 32'h0007);
      end
    end
    cycle("bp", 0, 0, 0, 1, 0);
    chk("bp.release", 32'(ifc.out_val), 32'd0);
    chk("bp.overrun", 32'(ifc.overrun), 32'd0);

    // Overrun: second word dropped, sticky flag.
    shift_word("ov", 16'h0005, 1'b0);
    cycle("ov", 0, 0, 0, 0, 0);
    shift_word("ov", 16'h000B, 1'b0);
    chk("ov.before", 32'(ifc.overrun), 32'd0);
    cycle("ov", 0, 0, 0, 0, 0);
    chk("ov.set", 32'(ifc.overrun), 32'd1);
    chk("ov.msg_kept", 32'(ifc.out_msg), 32'h0005);
    cycle("ov", 0, 0, 0, 1, 0);
    chk("ov.val_clr", 32'(ifc.out_val), 32'd0);
    chk("ov.sticky", 32'(ifc.overrun), 32'd1);

    // Simultaneous capture and handshake while streaming.
    cycle("sim", 0, 0, 0, 0, 1);
    shift_word("sim", 16'h1234, 1'b0);
    shift_word("sim", 16'hBEEF, 1'b0);
    chk("sim.old", 32'(ifc.out_msg), 32'h1234);
    cycle("sim", 1, 0, 0, 1, 0);
    chk("sim.val", 32'(ifc.out_val), 32'd1);
    chk("sim.new", 32'(ifc.out_msg), 32'hBEEF);
    chk("sim.ovr", 32'(ifc.overrun), 32'd0);

    // frame_clr abort.
    cycle("fc", 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cycle("fc", 1, 1, 0, 1, 0);
    drive(1, 1, 1, 1, 0);
    chk("fc.sipo_en", 32'(ifc.sipo_en), 32'd0);
    tick();
    cmp_model("fc");
    chk("fc.busy", 32'(ifc.busy), 32'd0);
    shift_word("fc", 16'h00FB, 1'b1);
    cycle("fc", 0, 0, 0, 0, 0);
    chk("fc.msg", 32'(ifc.out_msg), 32'h00FB);
    chk("fc.val", 32'(ifc.out_val), 32'd1);

    // Reset mid-word.
    for (int i = 0; i < 9; i++) cycle("rm", 1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 1);
    chk("rm.sipo_en", 32'(ifc.sipo_en), 32'd0);
    tick();
    cmp_model("rm");
    chk("rm.val0", 32'(ifc.out_val), 32'd0);
    chk("rm.msg0", 32'(ifc.out_msg), 32'd0);
    shift_word("rm", 16'h0003, 1'b0);
    cycle("rm", 0, 0, 0, 0, 0);
    chk("rm.msg", 32'(ifc.out_msg), 32'h0003);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle("rnd", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 300) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aidan_mcnay_deser_ctrl.md
Name: aidan_mcnay_deser_ctrl

Overview:
Framing controller that sits directly around the serial-in parallel-out shift register (aidan_mcnay_sipo) on the input path of the prime detector. It accepts one serial bit per strobe and forwards it to the SIPO. It counts bits and, once nbits have been shifted in, captures the SIPO's parallel word into an output register. The word is then offered downstream to the prime-check datapath through a val/rdy handshake, with overrun detection.

Parameters:
nbits, 16, word width in bits; equals the SIPO nbits. Legal range is 2 to 32.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ser_val  input  1  a serial bit is present on ser_data this cycle
ser_data  input  1  serial data bit, MSB of the word first
frame_clr  input  1  synchronous abort of the word currently being assembled
sipo_en  output  1  SIPO shift enable
sipo_data_in  output  1  SIPO serial input
sipo_data_out  input  nbits  SIPO parallel output; the most recent bit is at the LSB
out_msg  output  nbits  captured word
out_val  output  1  out_msg is valid
out_rdy  input  1  downstream accepts out_msg
busy  output  1  a partial word is in progress (bit_cnt != 0)
overrun  output  1  sticky: a completed word was dropped

Behaviour:
- Clock and reset: single clock domain, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: out_msg=0, out_val=0, overrun=0, bit_cnt=0, pending=0. busy=0 follows from bit_cnt.
- Combinational pass-through:
  - sipo_en = ser_val & ~frame_clr & ~reset.
  - sipo_data_in = ser_data.
  - No registering on this path.
- Bit counter: bit_cnt has width clog2(nbits) and counts 0..nbits-1.
  - Each accepted bit (sipo_en=1) increments bit_cnt.
  - The bit accepted while bit_cnt==nbits-1 wraps bit_cnt to 0 and sets pending=1 at that edge.
- Capture timing:
  - Let the final bit of a word be accepted in cycle N.
  - In cycle N+1, pending=1 and sipo_data_out holds the complete word.
  - At the end of cycle N+1, pending clears. The word is captured if out_val==0, or if out_val==1 and out_rdy==1 (the old word is handshaken at that same edge).
  - After a capture, out_val=1 from cycle N+2. Latency from final bit to out_val is 2 cycles.
  - A new bit accepted in cycle N+1 is legal. The capture samples the pre-shift SIPO contents, so the word is not corrupted.
- Overrun: if pending and out_val==1 and out_rdy==0, the new word is dropped and overrun is set to 1. out_msg and out_val are unchanged. overrun clears only on reset.
- Handshake:
  - out_val and out_msg hold stable until a cycle where out_val & out_rdy.
  - At that edge out_val clears, unless a capture occurs at the same edge, in which case out_val stays 1 and out_msg takes the new word.
  - out_rdy with out_val=0 has no effect.
- frame_clr:
  - Sets bit_cnt=0 and pending=0; the pending capture is cancelled.
  - The bit on ser_val in that cycle is ignored (sipo_en=0).
  - Does not affect out_val, out_msg or overrun.
- Priority: reset > frame_clr > capture/handshake > bit accept.
- Back-to-back words: with ser_val held high continuously, one word completes every nbits cycles. No bubble cycles are required between words.
- Reset mid-word or mid-handshake: all state returns to reset values in the next cycle. sipo_en is forced low during reset, so the SIPO does not shift on bits presented while reset is high.

Test Plan:
- Single word, nbits=16:
  - Stimulus: reset, then shift 0xFFF1 MSB-first with ser_val=1 for 16 cycles; out_rdy=1.
  - Response: out_val rises 2 cycles after the 16th bit with out_msg=0xFFF1; it drops one cycle later. busy is 1 during bits 2–16 and 0 after the wrap.
- Backpressure hold:
  - Stimulus: shift 0x0007 with out_rdy=0 for 10 cycles, then out_rdy=1.
  - Response: out_msg=0x0007 and out_val=1 stable throughout; out_val clears one cycle after out_rdy rises; overrun=0.
- Overrun:
  - Stimulus: shift 0x0005, keep out_rdy=0, then shift 0x000B.
  - Response: overrun=1 one cycle after the second word's pending cycle; out_msg stays 0x0005. After out_rdy=1, out_val clears and overrun remains 1.
- Simultaneous capture and handshake:
  - Stimulus: streaming ser_val=1; 0x1234 then 0xBEEF; out_rdy=1 asserted exactly in the second word's pending cycle.
  - Response: out_val stays 1 and out_msg changes 0x1234 to 0xBEEF with no gap; overrun=0.
- frame_clr abort:
  - Stimulus: shift 5 bits, assert frame_clr with ser_val=1, then shift 16 bits of 0x00FB.
  - Response: sipo_en=0 in the clr cycle; busy=0 after the clr; the next word completes only after 16 further bits; out_msg=0x00FB.
- Reset mid-word:
  - Stimulus: shift 9 bits, assert reset for 1 cycle with ser_val=1, then shift 0x0003.
  - Response: sipo_en=0 during reset; all outputs 0 after reset; the capture yields out_msg=0x0003 2 cycles after the 16th post-reset bit.
